// File: rtl/cva6_iti_block_fifo_if.sv
// Bundle between cva6_iti lanes, the block FIFO and the encoder stream.
// master: trace producer/consumer side; slave: the FIFO.
interface cva6_iti_block_fifo_if #(
  parameter int unsigned NrPorts     = 2,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ITYPE_LEN   = 3,
  parameter int unsigned IRETIRE_LEN = 32,
  parameter int unsigned CAUSE_LEN   = 5,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DROP_W      = 16
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [NrPorts-1:0]             in_valid_i;
  logic [NrPorts*IRETIRE_LEN-1:0] in_iretire_i;
  logic [NrPorts*ITYPE_LEN-1:0]   in_itype_i;
  logic [NrPorts-1:0]             in_ilastsize_i;
  logic [NrPorts*XLEN-1:0]        in_iaddr_i;
  logic [1:0]                     in_priv_i;
  logic [CAUSE_LEN-1:0]           in_cause_i;
  logic [XLEN-1:0]                in_tval_i;
  logic [63:0]                    in_cycles_i;
  logic                           flush_i;
  logic                           clr_i;

  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [IRETIRE_LEN-1:0] out_iretire_o;
  logic [ITYPE_LEN-1:0]   out_itype_o;
  logic                   out_ilastsize_o;
  logic [XLEN-1:0]        out_iaddr_o;
  logic [1:0]             out_priv_o;
  logic [CAUSE_LEN-1:0]   out_cause_o;
  logic [XLEN-1:0]        out_tval_o;
  logic [63:0]            out_cycles_o;

  logic [LVL_W-1:0]  level_o;
  logic              overflow_o;
  logic [DROP_W-1:0] drop_cnt_o;

  modport master (
    output in_valid_i, in_iretire_i, in_itype_i,
    output in_ilastsize_i, in_iaddr_i, in_priv_i,
    output in_cause_i, in_tval_i, in_cycles_i,
    output flush_i, clr_i, out_ready_i,
    input  out_valid_o, out_iretire_o, out_itype_o,
    input  out_ilastsize_o, out_iaddr_o, out_priv_o,
    input  out_cause_o, out_tval_o, out_cycles_o,
    input  level_o, overflow_o, drop_cnt_o
  );

  modport slave (
    input  in_valid_i, in_iretire_i, in_itype_i,
    input  in_ilastsize_i, in_iaddr_i, in_priv_i,
    input  in_cause_i, in_tval_i, in_cycles_i,
    input  flush_i, clr_i, out_ready_i,
    output out_valid_o, out_iretire_o, out_itype_o,
    output out_ilastsize_o, out_iaddr_o, out_priv_o,
    output out_cause_o, out_tval_o, out_cycles_o,
    output level_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/cva6_iti_block_fifo.sv
// Compacting multi-lane trace block FIFO with lossy, atomic admission.
// Ports: clk_i, rst_i (async, active-high), bus (slave: lanes in, stream out, status).
module cva6_iti_block_fifo #(
  parameter int unsigned NrPorts     = 2,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ITYPE_LEN   = 3,
  parameter int unsigned IRETIRE_LEN = 32,
  parameter int unsigned CAUSE_LEN   = 5,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DROP_W      = 16
) (
  input logic                   clk_i,
  input logic                   rst_i,
  cva6_iti_block_fifo_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(NrPorts + 1);

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic [ITYPE_LEN-1:0]   itype;
    logic                   ilastsize;
    logic [XLEN-1:0]        iaddr;
    logic [1:0]             priv;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [63:0]            cycles;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  level;
  logic              ovf;
  logic [DROP_W-1:0] drop_cnt;

  logic [CNT_W-1:0]  n;
  logic [CNT_W-1:0]  offs [NrPorts];
  entry_t            wdata [NrPorts];
  logic [LVL_W-1:0]  n_ext;
  logic [LVL_W-1:0]  free;
  logic [LVL_W-1:0]  n_wr;
  logic [LVL_W-1:0]  level_nxt;
  logic              push_any;
  logic              fits;
  logic              accept;
  logic              drop;
  logic              pop;
  logic [DROP_W-1:0] drop_base;
  logic [DROP_W:0]   drop_sum;
  logic [DROP_W-1:0] drop_sat;
  entry_t            head;

  // Slot offset of each lane = number of valid lanes below it.
  always_comb begin
    n = '0;
    for (int l = 0; l < NrPorts; l++) begin
      offs[l] = n;
      n = n + CNT_W'(bus.in_valid_i[l]);
    end
  end

  always_comb begin
    for (int l = 0; l < NrPorts; l++) begin
      wdata[l].iretire =
        bus.in_iretire_i[l*IRETIRE_LEN +: IRETIRE_LEN];
      wdata[l].itype =
        bus.in_itype_i[l*ITYPE_LEN +: ITYPE_LEN];
      wdata[l].ilastsize = bus.in_ilastsize_i[l];
      wdata[l].iaddr = bus.in_iaddr_i[l*XLEN +: XLEN];
      wdata[l].priv = bus.in_priv_i;
      wdata[l].cycles = bus.in_cycles_i;
      // Exception info belongs to lane 0 only.
      wdata[l].cause = (l == 0) ? bus.in_cause_i : '0;
      wdata[l].tval = (l == 0) ? bus.in_tval_i : '0;
    end
  end

  // Admission uses pre-pop occupancy: a same-cycle pop earns no credit.
  assign n_ext    = LVL_W'(n);
  assign free     = LVL_W'(DEPTH) - level;
  assign push_any = |bus.in_valid_i;
  assign fits     = (n_ext <= free);
  assign accept   = push_any && fits && !bus.flush_i;
  assign drop     = push_any && !fits && !bus.flush_i;
  assign pop      = (level != '0) && bus.out_ready_i
                    && !bus.flush_i;
  assign n_wr     = accept ? n_ext : '0;
  assign level_nxt = level + n_wr - LVL_W'(pop);

  // A drop in the same cycle as clr_i restarts the count from n.
  assign drop_base = bus.clr_i ? '0 : drop_cnt;
  assign drop_sum  = {1'b0, drop_base} + (DROP_W+1)'(n);
  assign drop_sat  = drop_sum[DROP_W] ? '1
                                      : drop_sum[DROP_W-1:0];

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NrPorts; l++) begin
      if (accept && bus.in_valid_i[l]) begin
        mem[wr_ptr + PTR_W'(offs[l])] <= wdata[l];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (bus.flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(n_wr);
        rd_ptr <= rd_ptr + PTR_W'(pop);
        level  <= level_nxt;
      end
      if (drop) begin
        ovf      <= 1'b1;
        drop_cnt <= drop_sat;
      end else if (bus.clr_i) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  // Head is zeroed while empty so stale storage never leaks out.
  assign head = (level != '0) ? mem[rd_ptr] : '0;

  assign bus.out_valid_o     = (level != '0);
  assign bus.out_iretire_o   = head.iretire;
  assign bus.out_itype_o     = head.itype;
  assign bus.out_ilastsize_o = head.ilastsize;
  assign bus.out_iaddr_o     = head.iaddr;
  assign bus.out_priv_o      = head.priv;
  assign bus.out_cause_o     = head.cause;
  assign bus.out_tval_o      = head.tval;
  assign bus.out_cycles_o    = head.cycles;
  assign bus.level_o         = level;
  assign bus.overflow_o      = ovf;
  assign bus.drop_cnt_o      = drop_cnt;

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < NrPorts))
  begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= NrPorts");
  end

  for (genvar g = 1; g < NrPorts; g++) begin : g_cause_chk
    a_no_cause : assert property (
      @(posedge clk_i) disable iff (rst_i)
      !bus.in_valid_i[g] || (wdata[g].cause == '0)
    );
  end
endmodule
